// File: rtl/fft_butterfly_8.sv
// fft_butterfly_8: radix-2 DIT butterfly controller for the 8-point FFT.
// Define FFT_BFLY_SAT_EN to clamp Y results instead of wrapping them.
module fft_butterfly_8 #(
  parameter int DATA_W  = 12,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_re,
  input  logic [DATA_W-1:0] a_im,
  input  logic [DATA_W-1:0] b_re,
  input  logic [DATA_W-1:0] b_im,
  input  logic [DATA_W-1:0] w_re,
  input  logic [DATA_W-1:0] w_im,
  output logic [DATA_W-1:0] mult_a,
  output logic [DATA_W-1:0] mult_b,
  output logic [DATA_W-1:0] mult_c,
  output logic [DATA_W-1:0] mult_d,
  output logic              mult_en,
  input  logic [23:0]       mult_real,
  input  logic [23:0]       mult_img,
  input  logic              mult_rdy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y0_re,
  output logic [DATA_W-1:0] y0_im,
  output logic [DATA_W-1:0] y1_re,
  output logic [DATA_W-1:0] y1_im,
  output logic              timeout_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
  localparam int SW = DATA_W + 2;

  typedef enum logic [1:0] {IDLE, WAIT, SUM, OUT} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] a_re_q, a_im_q;
  logic [DATA_W:0]   p_re, p_im;
  logic [SW-1:0]     a_re_x, a_im_x, p_re_x, p_im_x;
  logic [SW-1:0]     s0_re, s0_im, s1_re, s1_im;
  logic [DATA_W-1:0] r0_re, r0_im, r1_re, r1_im;
  logic              unused_mult;

  // only the low DATA_W+1 product bits carry the 13-bit product
  assign unused_mult = ^{mult_real[23:DATA_W+1], mult_img[23:DATA_W+1]};

  // sign-extend A and P, then form the full-width sum and difference
  always_comb begin
    a_re_x = {{2{a_re_q[DATA_W-1]}}, a_re_q};
    a_im_x = {{2{a_im_q[DATA_W-1]}}, a_im_q};
    p_re_x = {p_re[DATA_W], p_re};
    p_im_x = {p_im[DATA_W], p_im};
    s0_re  = a_re_x + p_re_x;
    s0_im  = a_im_x + p_im_x;
    s1_re  = a_re_x - p_re_x;
    s1_im  = a_im_x - p_im_x;
  end

`ifdef FFT_BFLY_SAT_EN
  function automatic logic [DATA_W-1:0] fit(input logic [SW-1:0] v);
    if (v[SW-1:DATA_W-1] == '0 || v[SW-1:DATA_W-1] == '1)
      fit = v[DATA_W-1:0];
    else if (v[SW-1])
      fit = {1'b1, {(DATA_W-1){1'b0}}};
    else
      fit = {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  // clamp each component into the signed DATA_W range
  always_comb begin
    r0_re = fit(s0_re);
    r0_im = fit(s0_im);
    r1_re = fit(s1_re);
    r1_im = fit(s1_im);
  end
`else
  logic unused_hi;
  assign unused_hi = ^{s0_re[SW-1:DATA_W], s0_im[SW-1:DATA_W],
                       s1_re[SW-1:DATA_W], s1_im[SW-1:DATA_W]};

  // keep the low DATA_W bits (two's-complement wrap)
  always_comb begin
    r0_re = s0_re[DATA_W-1:0];
    r0_im = s0_im[DATA_W-1:0];
    r1_re = s1_re[DATA_W-1:0];
    r1_im = s1_im[DATA_W-1:0];
  end
`endif

  // control FSM with registered handshake, operand and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      in_ready    <= 1'b1;
      mult_en     <= 1'b0;
      out_valid   <= 1'b0;
      timeout_err <= 1'b0;
      mult_a      <= '0;
      mult_b      <= '0;
      mult_c      <= '0;
      mult_d      <= '0;
      a_re_q      <= '0;
      a_im_q      <= '0;
      p_re        <= '0;
      p_im        <= '0;
      y0_re       <= '0;
      y0_im       <= '0;
      y1_re       <= '0;
      y1_im       <= '0;
    end else begin
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_re_q   <= a_re;
            a_im_q   <= a_im;
            mult_a   <= b_re;
            mult_b   <= b_im;
            mult_c   <= w_re;
            mult_d   <= w_im;
            mult_en  <= 1'b1;
            in_ready <= 1'b0;
            cnt      <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (mult_rdy) begin
            p_re    <= mult_real[DATA_W:0];
            p_im    <= mult_img[DATA_W:0];
            mult_en <= 1'b0;
            state   <= SUM;
          end else if (cnt == T_LAST) begin
            timeout_err <= 1'b1;
            mult_en     <= 1'b0;
            in_ready    <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SUM: begin
          y0_re     <= r0_re;
          y0_im     <= r0_im;
          y1_re     <= r1_re;
          y1_im     <= r1_im;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_butterfly_8.sv
// tb_fft_butterfly_8: vector table, random ops vs arithmetic model,
// plus backpressure, timeout and reset-in-WAIT sequences.
module tb_fft_butterfly_8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [11:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic [11:0] mult_a, mult_b, mult_c, mult_d;
  logic        mult_en, mult_rdy;
  logic [23:0] mult_real, mult_img;
  logic        out_valid, out_ready;
  logic [11:0] y0_re, y0_im, y1_re, y1_im;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  fft_butterfly_8 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .w_re(w_re), .w_im(w_im),
    .mult_a(mult_a), .mult_b(mult_b), .mult_c(mult_c), .mult_d(mult_d),
    .mult_en(mult_en), .mult_real(mult_real), .mult_img(mult_img),
    .mult_rdy(mult_rdy),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ar, ai, br, bi, wr, wi;
    int mr, mi, dly;
    int e0r, e0i, e1r, e1i;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string nm, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // product as seen by the butterfly: low 13 bits, signed
  function automatic int p13(input int v);
    int t;
    t = v & 32'h1fff;
    if (t >= 4096) t -= 8192;
    return t;
  endfunction

  // reduce an exact sum to a 12-bit signed result
  function automatic int red(input int v);
    int t;
`ifdef FFT_BFLY_SAT_EN
    t = v;
    if (t > 2047) t = 2047;
    if (t < -2048) t = -2048;
`else
    t = v & 32'hfff;
    if (t >= 2048) t -= 4096;
`endif
    return t;
  endfunction

  function automatic int rnd12();
    return int'($urandom_range(4095)) - 2048;
  endfunction

  task automatic run_op(input string nm,
                        input int ar, input int ai,
                        input int br, input int bi,
                        input int wr, input int wi,
                        input int mr, input int mi,
                        input int dly, input int hold,
                        input int e0r, input int e0i,
                        input int e1r, input int e1i);
    int n;
    logic [47:0] ops;
    n = 0;
    while (!in_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, " in_ready idle"}, in_ready, 1);
    a_re = 12'(ar); a_im = 12'(ai);
    b_re = 12'(br); b_im = 12'(bi);
    w_re = 12'(wr); w_im = 12'(wi);
    ops = {b_re, b_im, w_re, w_im};
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({nm, " mult_en"}, mult_en, 1);
    check({nm, " in_ready wait"}, in_ready, 0);
    check({nm, " operands"}, {mult_a, mult_b, mult_c, mult_d}, ops);
    b_re = 12'(rnd12()); w_im = 12'(rnd12());
    repeat (dly) begin
      @(posedge clk); #1;
    end
    check({nm, " operands held"}, {mult_a, mult_b, mult_c, mult_d}, ops);
    check({nm, " mult_en held"}, mult_en, 1);
    mult_rdy = 1'b1;
    mult_real = 24'(mr);
    mult_img = 24'(mi);
    @(posedge clk); #1;
    mult_rdy = 1'b0;
    mult_real = 24'($urandom);
    mult_img = 24'($urandom);
    check({nm, " mult_en drop"}, mult_en, 0);
    check({nm, " no early valid"}, out_valid, 0);
    @(posedge clk); #1;
    check({nm, " out_valid"}, out_valid, 1);
    check({nm, " y0_re"}, $signed(y0_re), e0r);
    check({nm, " y0_im"}, $signed(y0_im), e0i);
    check({nm, " y1_re"}, $signed(y1_re), e1r);
    check({nm, " y1_im"}, $signed(y1_im), e1i);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      a_re = 12'(rnd12());
      @(posedge clk); #1;
      check({nm, " bp valid"}, out_valid, 1);
      check({nm, " bp in_ready"}, in_ready, 0);
      check({nm, " bp y0_re"}, $signed(y0_re), e0r);
      check({nm, " bp y1_im"}, $signed(y1_im), e1i);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({nm, " handoff"}, out_valid, 0);
    check({nm, " in_ready back"}, in_ready, 1);
    check({nm, " no restart"}, mult_en, 0);
  endtask

  initial begin
    int n, saw, ar, ai, br, bi, wr, wi, mr, mi;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; mult_rdy = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
    mult_real = '0; mult_img = '0;

    tbl[0] = '{100, 50, 64, 0, 128, 0, 64, 0, 3, 164, 50, 36, 50};
    tbl[2] = '{0, 0, -300, 5, 128, 0, -300, 5, 0, -300, 5, 300, -5};
    tbl[4] = '{-5, 7, 10, 20, 64, -64, 15, -3, 63, 10, 4, -20, 10};
`ifdef FFT_BFLY_SAT_EN
    tbl[1] = '{2000, -2000, 100, 100, 128, 0, 100, 100, 1,
               2047, -1900, 1900, -2048};
    tbl[3] = '{0, 0, 1, 2, 3, 4, 5000, -5000, 2,
               -2048, 2047, 2047, -2048};
    tbl[5] = '{-2048, 2047, 0, 0, 0, 0, -1, 1, 62,
               -2048, 2047, -2047, 2046};
`else
    tbl[1] = '{2000, -2000, 100, 100, 128, 0, 100, 100, 1,
               -1996, -1900, 1900, 1996};
    tbl[3] = '{0, 0, 1, 2, 3, 4, 5000, -5000, 2,
               904, -904, -904, 904};
    tbl[5] = '{-2048, 2047, 0, 0, 0, 0, -1, 1, 62,
               2047, -2048, -2047, 2046};
`endif

    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset mult_en", mult_en, 0);
    check("reset out_valid", out_valid, 0);
    check("reset timeout_err", timeout_err, 0);
    check("reset mult ops", {mult_a, mult_b, mult_c, mult_d}, 0);
    check("reset y", {y0_re, y0_im, y1_re, y1_im}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), tbl[i].ar, tbl[i].ai,
             tbl[i].br, tbl[i].bi, tbl[i].wr, tbl[i].wi,
             tbl[i].mr, tbl[i].mi, tbl[i].dly, 0,
             tbl[i].e0r, tbl[i].e0i, tbl[i].e1r, tbl[i].e1i);

    run_op("backpressure", 100, 50, 64, 0, 128, 0, 64, 0, 0, 5,
           164, 50, 36, 50);

    for (int i = 0; i < 40; i++) begin
      ar = rnd12(); ai = rnd12();
      br = rnd12(); bi = rnd12();
      wr = rnd12(); wi = rnd12();
      mr = (br * wr - bi * wi) >>> 7;
      mi = (br * wi + bi * wr) >>> 7;
      run_op($sformatf("rand%0d", i), ar, ai, br, bi, wr, wi, mr, mi,
             int'($urandom_range(6)), int'($urandom_range(2)),
             red(ar + p13(mr)), red(ai + p13(mi)),
             red(ar - p13(mr)), red(ai - p13(mi)));
    end

    // timeout: multiplier never answers
    a_re = 12'd1; b_re = 12'd2; w_re = 12'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    saw = 0;
    while (mult_en && n < 200) begin
      n++;
      if (out_valid || timeout_err) saw = 1;
      @(posedge clk); #1;
    end
    check("timeout en cycles", n, 64);
    check("timeout early flag", saw, 0);
    check("timeout pulse", timeout_err, 1);
    check("timeout in_ready", in_ready, 1);
    check("timeout out_valid", out_valid, 0);
    @(posedge clk); #1;
    check("timeout pulse end", timeout_err, 0);
    check("timeout no output", out_valid, 0);

    // reset during the second WAIT cycle
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rstwait en before", mult_en, 1);
    rst = 1'b1;
    #1;
    check("rstwait mult_en", mult_en, 0);
    check("rstwait in_ready", in_ready, 1);
    check("rstwait ops", {mult_a, mult_b, mult_c, mult_d}, 0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    mult_rdy = 1'b1;
    mult_real = 24'd5;
    mult_img = 24'd5;
    @(posedge clk); #1;
    mult_rdy = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("rstwait no output", out_valid, 0);
    check("rstwait idle", in_ready, 1);
    check("rstwait y cleared", {y0_re, y0_im, y1_re, y1_im}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
